// File: rtl/proc_net_interface.sv
// rtl/proc_net_interface.sv - processor-to-mesh network interface with TX FIFO/packetizer and RX unpacker
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   p_configure/p_valid   processor request {dest[10:9], payload[8:0]} and its valid
//   p_ready               request FIFO can accept (low in reset or when full)
//   block_all_paths       global TX stall
//   r_input/r_ready       flit {valid, src, dest, seq, payload} to router, router accept
//   r_output              flit from router, same format
//   r_output_ready        interface can take an RX flit
//   p_recieve_data/src    received payload and source id
//   p_recieve_valid/ack   received data valid, processor consumed it
//   misroute_count        saturating count of flits dropped for wrong destination

module proc_net_interface #(
  parameter logic [1:0] NODE_ID    = 2'd0,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [10:0] p_configure,
  input  logic        p_valid,
  output logic        p_ready,
  input  logic        block_all_paths,
  output logic [17:0] r_input,
  input  logic        r_ready,
  input  logic [17:0] r_output,
  output logic        r_output_ready,
  output logic [8:0]  p_recieve_data,
  output logic [1:0]  p_recieve_src,
  output logic        p_recieve_valid,
  input  logic        p_recieve_ack,
  output logic [7:0]  misroute_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SEND, STALL} tx_state_t;

  logic [10:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop, can_load;
  logic [10:0]   head;
  logic [17:0]   new_flit, flit_d;
  logic [3:0]    seq_q, seq_d;
  tx_state_t     state_q, state_d;
  logic          rx_accept;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign p_ready  = reset && !full;
  assign push     = p_valid && p_ready;
  assign can_load = !empty && !block_all_paths;
  assign head     = fifo_mem[rd_ptr];
  assign new_flit = {1'b1, NODE_ID, head[10:9], seq_q, head[8:0]};

  // Storage needs no reset: the count/pointers define what is live.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= p_configure;
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      r_input <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      r_input <= flit_d;
      seq_q   <= seq_d;
    end
  end

  // An accepted flit may be replaced in the same edge (back-to-back);
  // a stalled flit keeps its body so it resumes with the same seq.
  always_comb begin
    state_d = state_q;
    flit_d  = r_input;
    seq_d   = seq_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_load) begin
          pop     = 1'b1;
          flit_d  = new_flit;
          seq_d   = seq_q + 4'd1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (r_ready) begin
          if (can_load) begin
            pop    = 1'b1;
            flit_d = new_flit;
            seq_d  = seq_q + 4'd1;
          end else begin
            flit_d  = '0;
            state_d = IDLE;
          end
        end else if (block_all_paths) begin
          flit_d[17] = 1'b0;
          state_d    = STALL;
        end
      end
      STALL: begin
        if (!block_all_paths) begin
          flit_d[17] = 1'b1;
          state_d    = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Held at 0 during reset so every output reads 0 while reset is low.
  assign r_output_ready = reset && !p_recieve_valid;
  assign rx_accept      = r_output[17] && r_output_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_recieve_data  <= '0;
      p_recieve_src   <= '0;
      p_recieve_valid <= 1'b0;
      misroute_count  <= '0;
    end else begin
      if (p_recieve_valid && p_recieve_ack) begin
        p_recieve_valid <= 1'b0;
      end else if (rx_accept) begin
        if (r_output[14:13] == NODE_ID) begin
          p_recieve_data  <= r_output[8:0];
          p_recieve_src   <= r_output[16:15];
          p_recieve_valid <= 1'b1;
        end else if (misroute_count != 8'hFF) begin
          misroute_count <= misroute_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_proc_net_interface.sv
// tb/tb_proc_net_interface.sv - scoreboard testbench for proc_net_interface

module tb_proc_net_interface;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] p_configure = '0;
  logic        p_valid = 1'b0;
  logic        p_ready;
  logic        block_all_paths = 1'b0;
  logic [17:0] r_input;
  logic        r_ready = 1'b0;
  logic [17:0] r_output = '0;
  logic        r_output_ready;
  logic [8:0]  p_recieve_data;
  logic [1:0]  p_recieve_src;
  logic        p_recieve_valid;
  logic        p_recieve_ack = 1'b0;
  logic [7:0]  misroute_count;

  proc_net_interface #(.NODE_ID(2'd2), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .p_configure(p_configure), .p_valid(p_valid),
    .p_ready(p_ready), .block_all_paths(block_all_paths), .r_input(r_input),
    .r_ready(r_ready), .r_output(r_output), .r_output_ready(r_output_ready),
    .p_recieve_data(p_recieve_data), .p_recieve_src(p_recieve_src),
    .p_recieve_valid(p_recieve_valid), .p_recieve_ack(p_recieve_ack),
    .misroute_count(misroute_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [17:0] tx_q [$];
  logic [10:0] rx_q [$];
  logic [3:0]  seq_m = '0;
  int          mis_m = 0;
  logic        rxv_m = 1'b0;
  logic        pend_valid = 1'b0;
  logic [17:0] pend_flit = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic flush_model();
    tx_q.delete();
    rx_q.delete();
    seq_m      = '0;
    mis_m      = 0;
    rxv_m      = 1'b0;
    pend_valid = 1'b0;
  endtask

  // Monitor: everything sampled at negedge describes the coming rising edge.
  always @(negedge clock) begin
    if (reset) begin
      logic [17:0] exp_flit;
      logic [10:0] exp_rx;
      // RX side: compare state, then advance the model for the coming edge
      check("misroute_count", 32'(misroute_count), 32'(mis_m));
      check("rx_valid", 32'(p_recieve_valid), 32'(rxv_m));
      check("rx_ready", 32'(r_output_ready), 32'(!rxv_m));
      if (rxv_m && p_recieve_ack) begin
        if (rx_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rx_unexpected actual=%0h required=none", {p_recieve_src, p_recieve_data});
        end else begin
          exp_rx = rx_q.pop_front();
          check("rx_data", 32'({p_recieve_src, p_recieve_data}), 32'(exp_rx));
        end
        rxv_m = 1'b0;
      end else if (r_output[17] && !rxv_m) begin
        if (r_output[14:13] == 2'd2) begin
          rx_q.push_back({r_output[16:15], r_output[8:0]});
          rxv_m = 1'b1;
        end else if (mis_m < 255) begin
          mis_m++;
        end
      end
      // TX side: a presented flit must not change until accepted
      if (pend_valid) check("tx_hold", 32'(r_input[16:0]), 32'(pend_flit[16:0]));
      if (r_input[17] && !pend_valid) begin
        pend_valid = 1'b1;
        pend_flit  = r_input;
      end
      if (r_input[17] && r_ready) begin
        if (tx_q.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_unexpected actual=%0h required=none", r_input);
        end else begin
          exp_flit = tx_q.pop_front();
          check("tx_flit", 32'(r_input), 32'(exp_flit));
        end
        pend_valid = 1'b0;
      end
      if (p_valid && p_ready) begin
        tx_q.push_back({1'b1, 2'd2, p_configure[10:9], seq_m, p_configure[8:0]});
        seq_m = seq_m + 4'd1;
      end
    end
  end

  int n;

  initial begin
    flush_model();
    #23 reset = 1'b1;
    tick();

    // Single request, latency and seq increment
    p_valid = 1'b1; p_configure = 11'b01000000011; r_ready = 1'b1;
    tick();
    p_valid = 1'b0;
    tick();
    check("first_flit", 32'(r_input), 32'h32003);
    tick();
    check("first_cleared", 32'(r_input), 32'h0);
    p_valid = 1'b1;
    tick();
    p_valid = 1'b0;
    tick();
    check("second_flit_seq1", 32'(r_input), 32'h32203);
    tick();
    check("second_cleared", 32'(r_input), 32'h0);

    // Capacity: FIFO_DEPTH entries plus one flit held on r_input
    r_ready = 1'b0; p_valid = 1'b1; n = 0;
    for (int i = 0; i < 10; i++) begin
      p_configure = 11'($urandom);
      @(negedge clock);
      if (p_ready) n++;
      tick();
    end
    p_valid = 1'b0;
    check("capacity", 32'(n), 32'd5);
    check("p_ready_full", 32'(p_ready), 32'd0);
    r_ready = 1'b1;
    repeat (8) tick();

    // Continuous traffic past the seq wrap
    p_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      p_configure = 11'($urandom);
      tick();
    end
    p_valid = 1'b0;
    repeat (8) tick();
    check("tx_drained_wrap", 32'(tx_q.size()), 32'd0);

    // Stall while presented
    r_ready = 1'b0; p_valid = 1'b1; p_configure = 11'($urandom);
    tick();
    p_valid = 1'b0;
    tick();
    check("stall_presented", 32'(r_input[17]), 32'd1);
    block_all_paths = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid_low", 32'(r_input[17]), 32'd0);
    end
    block_all_paths = 1'b0; r_ready = 1'b1;
    tick();
    check("stall_resumed", 32'(r_input[17]), 32'd1);
    tick();
    check("stall_accepted", 32'(r_input), 32'h0);

    // RX directed: capture, blocking, ack
    r_output = {1'b1, 2'b01, 2'b10, 4'h0, 9'h0AB};
    tick();
    r_output = {1'b1, 2'b11, 2'b10, 4'h5, 9'h155};
    check("rx1_valid", 32'(p_recieve_valid), 32'd1);
    check("rx1_data", 32'(p_recieve_data), 32'h0AB);
    check("rx1_src", 32'(p_recieve_src), 32'd1);
    check("rx1_ready_low", 32'(r_output_ready), 32'd0);
    repeat (3) tick();
    check("rx1_held", 32'({p_recieve_valid, p_recieve_data}), 32'h2AB);
    p_recieve_ack = 1'b1;
    tick();
    p_recieve_ack = 1'b0;
    check("rx_ack_drop", 32'(p_recieve_valid), 32'd0);
    check("rx_ack_ready", 32'(r_output_ready), 32'd1);
    tick();
    r_output = '0;
    check("rx2_captured", 32'({p_recieve_valid, p_recieve_src, p_recieve_data}), 32'h0F55);
    p_recieve_ack = 1'b1;
    tick();
    p_recieve_ack = 1'b0;

    // Randomized mixed traffic
    for (int i = 0; i < 600; i++) begin
      p_valid         = 1'($urandom);
      p_configure     = 11'($urandom);
      block_all_paths = ($urandom_range(0, 4) == 0);
      r_ready         = 1'($urandom);
      r_output        = {1'($urandom), 2'($urandom),
                         ($urandom_range(0, 1) == 1) ? 2'd2 : 2'($urandom),
                         4'($urandom), 9'($urandom)};
      p_recieve_ack   = 1'($urandom);
      tick();
    end
    p_valid = 1'b0; block_all_paths = 1'b0; r_ready = 1'b1; r_output = '0; p_recieve_ack = 1'b1;
    repeat (20) tick();
    p_recieve_ack = 1'b0;
    check("rand_tx_drained", 32'(tx_q.size()), 32'd0);
    check("rand_rx_drained", 32'(rx_q.size()), 32'd0);

    // Misroute saturation
    for (int i = 0; i < 300; i++) begin
      r_output = {1'b1, 2'($urandom), 2'd3, 4'($urandom), 9'($urandom)};
      tick();
    end
    r_output = '0;
    tick();
    check("misroute_sat", 32'(misroute_count), 32'd255);
    check("misroute_none_delivered", 32'(p_recieve_valid), 32'd0);

    // Reset with traffic in flight
    r_ready = 1'b0; p_valid = 1'b1; n = 0;
    while (n < 4) begin
      p_configure = 11'($urandom);
      @(negedge clock);
      if (p_ready) n++;
      tick();
    end
    p_valid = 1'b0;
    r_output = {1'b1, 2'd1, 2'd2, 4'd0, 9'h1C3};
    tick();
    #2 reset = 1'b0;
    #1;
    flush_model();
    check("rst_r_input", 32'(r_input), 32'h0);
    check("rst_p_ready", 32'(p_ready), 32'd0);
    check("rst_rx", 32'({p_recieve_valid, p_recieve_src, p_recieve_data}), 32'h0);
    check("rst_rx_ready", 32'(r_output_ready), 32'd0);
    check("rst_misroute", 32'(misroute_count), 32'h0);
    r_output = '0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("post_rst_ready", 32'(p_ready), 32'd1);
    r_ready = 1'b1; p_valid = 1'b1; p_configure = 11'b11000001111;
    tick();
    p_valid = 1'b0;
    tick();
    check("post_rst_seq0", 32'(r_input), 32'h3600F);
    repeat (4) tick();
    check("post_rst_empty", 32'(r_input), 32'h0);
    check("final_tx_q", 32'(tx_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
